quad_decoder: RTL and testbench

- Quadrature decoder that drives position counting from an incremental encoder.
- Takes the raw asynchronous A/B phase inputs and synchronizes and glitch-filters them.
- Decodes Gray-code transitions into step pulses and an up/down direction, and keeps a wrapping position count.
- Sits between the encoder pins and the up/down counting logic; its step/up_down outputs follow the counter convention (up_down=1 means increment).

---
 rtl/quad_decoder.sv | 157 +++++++++++++++
 tb/tb_quad_decoder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// Quadrature decoder: 2-flop synchronizer, run-length glitch filter, Gray-code step decode, wrapping count.
// Optional index input: define QUAD_INDEX_EN to add phase_z, which zeroes count on a Z rising edge at AB=00.
module quad_decoder #(
  parameter int CNT_W    = 4,
  parameter int FILT_LEN = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             phase_a,
  input  logic             phase_b,
`ifdef QUAD_INDEX_EN
  input  logic             phase_z,
`endif
  input  logic             clear,
  input  logic             err_clr,
  output logic             step,
  output logic             up_down,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  localparam logic [3:0]       FL  = 4'(FILT_LEN);
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Position of an {A,B} state along the up sequence 00->10->11->01.
  function automatic logic [1:0] gidx(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction

  logic [1:0]       sync1_q, sync2_q, s_prev_q;
  logic [3:0]       fcnt_q, fcnt_d, fcnt_inc;
  logic [1:0]       filt_q, filt_d, filt_old_q;
  logic [1:0]       vld_q;
  logic [3:0]       agree_q, agree_d, agree_inc;
  logic             init_q, init_d;
  logic             step_q, step_d, up_down_q, up_down_d, err_q, err_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             chg, illegal, up, zero_cnt;

  // Filter: s must differ from the filtered value for FL consecutive samples before it is adopted.
  always_comb begin
    fcnt_inc = (sync2_q != s_prev_q) ? 4'd1 : fcnt_q + 4'd1;
    fcnt_d   = 4'd0;
    filt_d   = filt_q;
    if (sync2_q != filt_q) begin
      if (fcnt_inc >= FL) filt_d = sync2_q;
      else                fcnt_d = fcnt_inc;
    end
  end

`ifdef QUAD_INDEX_EN
  logic       zsync1_q, zsync2_q, zprev_q, zfilt_q, zfilt_d, zfilt_old_q;
  logic [3:0] zcnt_q, zcnt_d, zcnt_inc;

  always_comb begin
    zcnt_inc = (zsync2_q != zprev_q) ? 4'd1 : zcnt_q + 4'd1;
    zcnt_d   = 4'd0;
    zfilt_d  = zfilt_q;
    if (zsync2_q != zfilt_q) begin
      if (zcnt_inc >= FL) zfilt_d = zsync2_q;
      else                zcnt_d  = zcnt_inc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zsync1_q    <= 1'b0;
      zsync2_q    <= 1'b0;
      zprev_q     <= 1'b0;
      zcnt_q      <= 4'd0;
      zfilt_q     <= 1'b0;
      zfilt_old_q <= 1'b0;
    end else begin
      zsync1_q    <= phase_z;
      zsync2_q    <= zsync1_q;
      zprev_q     <= zsync2_q;
      zcnt_q      <= zcnt_d;
      zfilt_q     <= zfilt_d;
      zfilt_old_q <= zfilt_q;
    end
  end

  assign zero_cnt = clear | (zfilt_q & ~zfilt_old_q & (filt_q == 2'b00));
`else
  assign zero_cnt = clear;
`endif

  assign chg     = (filt_q != filt_old_q);
  assign illegal = ((filt_q ^ filt_old_q) == 2'b11);
  assign up      = (gidx(filt_q) == gidx(filt_old_q) + 2'd1);

  // Init completes either on the first filtered change (init-only) or once the reset-time
  // value 00 is confirmed stable by the same run-length rule, after the synchronizer has flushed.
  always_comb begin
    agree_inc = agree_q + 4'd1;
    agree_d   = 4'd0;
    init_d    = init_q;
    step_d    = 1'b0;
    up_down_d = up_down_q;
    count_d   = count_q;
    err_d     = err_q;
    if (!init_q && vld_q[1] && sync2_q == filt_q) begin
      if (agree_inc >= FL) init_d = 1'b1;
      else                 agree_d = agree_inc;
    end
    if (chg) begin
      if (!init_q) begin
        init_d = 1'b1;
      end else if (!illegal) begin
        step_d    = 1'b1;
        up_down_d = up;
        count_d   = up ? count_q + ONE : count_q - ONE;
      end
    end
    if (zero_cnt) count_d = '0;
    if (err_clr)  err_d = 1'b0;
    if (chg && init_q && illegal) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 2'b00;
      sync2_q    <= 2'b00;
      s_prev_q   <= 2'b00;
      fcnt_q     <= 4'd0;
      filt_q     <= 2'b00;
      filt_old_q <= 2'b00;
      vld_q      <= 2'b00;
      agree_q    <= 4'd0;
      init_q     <= 1'b0;
      step_q     <= 1'b0;
      up_down_q  <= 1'b1;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      sync1_q    <= {phase_a, phase_b};
      sync2_q    <= sync1_q;
      s_prev_q   <= sync2_q;
      fcnt_q     <= fcnt_d;
      filt_q     <= filt_d;
      filt_old_q <= filt_q;
      vld_q      <= {vld_q[0], 1'b1};
      agree_q    <= agree_d;
      init_q     <= init_d;
      step_q     <= step_d;
      up_down_q  <= up_down_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

  assign step    = step_q;
  assign up_down = up_down_q;
  assign count   = count_q;
  assign err     = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder (CNT_W=4, FILT_LEN=3): steps, wrap, glitch, illegal, clear, reset.
module tb_quad_decoder;

  logic       clk = 1'b0;
  logic       reset, phase_a, phase_b, clear, err_clr;
  logic       step, up_down, err;
  logic [3:0] count;

  int vectors     = 0;
  int miscompares = 0;
  int p, f;
  logic [1:0] seq [4];

  quad_decoder #(.CNT_W(4), .FILT_LEN(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .phase_a (phase_a),
    .phase_b (phase_b),
    .clear   (clear),
    .err_clr (err_clr),
    .step    (step),
    .up_down (up_down),
    .count   (count),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs n cycles from a negedge, counting step pulses; clear/err_clr optionally driven during cycle 5->6.
  task automatic watch(input int n, input logic clr5, input logic eclr5, output int pulses, output int first);
    pulses = 0;
    first  = 0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (step) begin
        pulses++;
        if (first == 0) first = c;
      end
      if (c == 5) begin
        clear   = clr5;
        err_clr = eclr5;
      end else begin
        clear   = 1'b0;
        err_clr = 1'b0;
      end
    end
  endtask

  task automatic move(input logic a, input logic b, input logic clr5, input logic eclr5,
                      input int ep, input int ef, input logic eud, input logic [3:0] ecnt,
                      input logic eerr, input string tag);
    int mp, mf;
    phase_a = a;
    phase_b = b;
    watch(10, clr5, eclr5, mp, mf);
    $display("move %s: AB=%b%b pulses=%0d at=%0d up_down=%b count=%0d err=%b",
             tag, a, b, mp, mf, up_down, count, err);
    chk({tag, ".pulses"}, mp, ep);
    chk({tag, ".pulse_cycle"}, mf, ef);
    chk({tag, ".up_down"}, up_down, eud);
    chk({tag, ".count"}, count, ecnt);
    chk({tag, ".err"}, err, eerr);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    $display("clear: count=%0d", count);
    chk("clear.count", count, 0);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    $display("err_clr: err=%b", err);
    chk("err_clr.err", err, 0);
  endtask

  initial begin
    seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
    reset = 1'b1; phase_a = 1'b0; phase_b = 1'b0; clear = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    $display("reset: step=%b up_down=%b count=%0d err=%b", step, up_down, count, err);
    chk("reset.step", step, 0);
    chk("reset.up_down", up_down, 1);
    chk("reset.count", count, 0);
    chk("reset.err", err, 0);
    reset = 1'b0;
    watch(8, 1'b0, 1'b0, p, f);
    chk("idle.pulses", p, 0);

    move(1'b1, 1'b0, 1'b0, 1'b0, 1, 6, 1'b1, 4'd1, 1'b0, "first_up");
    pulse_clear();

    for (int i = 1; i <= 16; i++) begin
      int idx;
      idx = (i + 1) % 4;
      move(seq[idx][1], seq[idx][0], 1'b0, 1'b0, 1, 6, 1'b1, 4'(i % 16), 1'b0, "fwd");
    end

    // Down step with clear in the decode cycle: pulse and direction still reported, count forced to 0.
    move(1'b0, 1'b0, 1'b1, 1'b0, 1, 6, 1'b0, 4'd0, 1'b0, "down_with_clear");
    move(1'b0, 1'b1, 1'b0, 1'b0, 1, 6, 1'b0, 4'd15, 1'b0, "down_wrap");
    move(1'b0, 1'b0, 1'b0, 1'b0, 1, 6, 1'b1, 4'd0, 1'b0, "up_wrap");

    phase_a = 1'b1;
    repeat (2) @(negedge clk);
    phase_a = 1'b0;
    watch(10, 1'b0, 1'b0, p, f);
    $display("glitch2: pulses=%0d count=%0d err=%b", p, count, err);
    chk("glitch2.pulses", p, 0);
    chk("glitch2.count", count, 0);
    chk("glitch2.err", err, 0);

    phase_a = 1'b1;
    repeat (3) @(negedge clk);
    phase_a = 1'b0;
    watch(12, 1'b0, 1'b0, p, f);
    $display("glitch3: pulses=%0d first=%0d up_down=%b count=%0d", p, f, up_down, count);
    chk("glitch3.pulses", p, 2);
    chk("glitch3.first", f, 3);
    chk("glitch3.up_down", up_down, 0);
    chk("glitch3.count", count, 0);

    move(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 4'd0, 1'b1, "illegal");
    pulse_err_clr();
    move(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 4'd0, 1'b1, "illegal_with_err_clr");
    pulse_err_clr();

    // Walk to AB=11 with count=7.
    move(1'b0, 1'b1, 1'b0, 1'b0, 1, 6, 1'b0, 4'd15, 1'b0, "prep_down");
    pulse_clear();
    for (int k = 1; k <= 7; k++) begin
      int idx;
      idx = (3 + k) % 4;
      move(seq[idx][1], seq[idx][0], 1'b0, 1'b0, 1, 6, 1'b1, 4'(k), 1'b0, "prep_up");
    end

    reset = 1'b1;
    #1;
    $display("mid reset: count=%0d step=%b up_down=%b err=%b", count, step, up_down, err);
    chk("midreset.count", count, 0);
    chk("midreset.up_down", up_down, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    watch(12, 1'b0, 1'b0, p, f);
    $display("post reset init: pulses=%0d count=%0d err=%b", p, count, err);
    chk("reinit.pulses", p, 0);
    chk("reinit.count", count, 0);
    chk("reinit.err", err, 0);
    move(1'b0, 1'b1, 1'b0, 1'b0, 1, 6, 1'b1, 4'd1, 1'b0, "post_reset_up");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
